// File: rtl/risc16_pkg.sv
// Shared types for the RiSC-16 trace buffer: FSM states and the FIFO entry layout.
// The entry gains a 32-bit timestamp when RISC16_TRACE_TIMESTAMP_EN is defined.
package risc16_pkg;

    localparam int REG_W  = 3;
    localparam int WORD_W = 16;
    localparam int SEQ_W  = 16;
    localparam int TS_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FROZEN  = 2'd3
    } trc_state_e;

    typedef struct packed {
`ifdef RISC16_TRACE_TIMESTAMP_EN
        logic [TS_W-1:0]   ts;
`endif
        logic [WORD_W-1:0] pc;
        logic [REG_W-1:0]  rg;
        logic [WORD_W-1:0] data;
        logic [SEQ_W-1:0]  seq;
    } trace_entry_t;

    localparam int ENTRY_W = $bits(trace_entry_t);

    // r0 is hard-wired to zero on RiSC-16, so writes to it carry no information.
    function automatic logic is_qualified(input logic we, input logic [REG_W-1:0] rg);
        return we && (rg != '0);
    endfunction

endpackage

// File: rtl/risc16_trace_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; head reads as zero when empty.
// Push is accepted when not full or when a pop frees a slot in the same cycle.
module risc16_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 51
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;
    assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

    // Masking the head keeps the outputs at zero after reset/flush without resetting the array.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/risc16_trace_buffer.sv
// Trace capture of RiSC-16 register-file writebacks into a FWFT FIFO drained by a host.
// Optional per-entry cycle timestamp (tr_ts) when RISC16_TRACE_TIMESTAMP_EN is defined.
module risc16_trace_buffer
    import risc16_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [WORD_W-1:0] wb_pc,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [WORD_W-1:0] wb_data,
    input  logic              cap_en,
    input  logic              trig_en,
    input  logic [WORD_W-1:0] trig_pc,
    input  logic              stop_on_full,
    input  logic              clear,
    output logic              tr_valid,
    input  logic              tr_ready,
    output logic [WORD_W-1:0] tr_pc,
    output logic [REG_W-1:0]  tr_reg,
    output logic [WORD_W-1:0] tr_data,
    output logic [SEQ_W-1:0]  tr_seq,
`ifdef RISC16_TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]   tr_ts,
`endif
    output logic [1:0]        state,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);
    trc_state_e        state_q;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              overflow_q;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic qual, pop, room, trig_hit, cap_evt, push, drop;
    logic fifo_full, fifo_empty;
    trace_entry_t wr_entry, head;
    logic [ENTRY_W-1:0] fifo_rdata;

`ifdef RISC16_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        ts_q <= '0;
        else if (clear) ts_q <= '0;
        else            ts_q <= ts_q + TS_W'(1);
    end
`endif

    // Pop is evaluated first so a full FIFO with a same-cycle pop still has room.
    always_comb begin
        qual     = is_qualified(wb_we, wb_reg);
        pop      = !fifo_empty && tr_ready && !clear;
        room     = !fifo_full || pop;
        trig_hit = (state_q == ST_ARMED) && cap_en && qual && (wb_pc == trig_pc);
        cap_evt  = trig_hit || ((state_q == ST_CAPTURE) && cap_en && qual);
        push     = cap_evt && room && !clear;
        drop     = cap_evt && !room && !clear;
    end

    always_comb begin
        wr_entry      = '0;
`ifdef RISC16_TRACE_TIMESTAMP_EN
        wr_entry.ts   = ts_q;
`endif
        wr_entry.pc   = wb_pc;
        wr_entry.rg   = wb_reg;
        wr_entry.data = wb_data;
        wr_entry.seq  = seq_q;
    end

    risc16_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (clear),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head     = trace_entry_t'(fifo_rdata);
    assign tr_valid = !fifo_empty;
    assign tr_pc    = head.pc;
    assign tr_reg   = head.rg;
    assign tr_data  = head.data;
    assign tr_seq   = head.seq;
`ifdef RISC16_TRACE_TIMESTAMP_EN
    assign tr_ts    = head.ts;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (clear) begin
            state_q <= ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cap_en) state_q <= trig_en ? ST_ARMED : ST_CAPTURE;
                end
                ST_ARMED: begin
                    if (!cap_en)       state_q <= ST_IDLE;
                    else if (trig_hit) state_q <= (drop && stop_on_full) ? ST_FROZEN : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (!cap_en)                  state_q <= ST_IDLE;
                    else if (drop && stop_on_full) state_q <= ST_FROZEN;
                end
                ST_FROZEN: state_q <= ST_FROZEN;
            endcase
        end
    end

    assign seq_d      = seq_q + SEQ_W'(1);
    assign drop_cnt_d = (drop_cnt_q == '1) ? drop_cnt_q : drop_cnt_q + DROP_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (clear) begin
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (push) seq_q <= seq_d;
            if (drop) begin
                overflow_q <= 1'b1;
                drop_cnt_q <= drop_cnt_d;
            end
        end
    end

    assign state    = state_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_risc16_trace_buffer.sv
// Directed + randomized bench for risc16_trace_buffer against a queue-based reference model.
module tb_risc16_trace_buffer;
    localparam int DEPTH  = 16;
    localparam int DROP_W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [15:0] wb_pc;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        cap_en, trig_en, stop_on_full, clear, tr_ready;
    logic [15:0] trig_pc;
    logic        tr_valid;
    logic [15:0] tr_pc, tr_data, tr_seq;
    logic [2:0]  tr_reg;
    logic [1:0]  state;
    logic        overflow;
    logic [DROP_W-1:0] drop_cnt;
`ifdef RISC16_TRACE_TIMESTAMP_EN
    logic [31:0] tr_ts;
`endif

    risc16_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_pc(wb_pc), .wb_reg(wb_reg), .wb_data(wb_data),
        .cap_en(cap_en), .trig_en(trig_en), .trig_pc(trig_pc),
        .stop_on_full(stop_on_full), .clear(clear),
        .tr_valid(tr_valid), .tr_ready(tr_ready),
        .tr_pc(tr_pc), .tr_reg(tr_reg), .tr_data(tr_data), .tr_seq(tr_seq),
`ifdef RISC16_TRACE_TIMESTAMP_EN
        .tr_ts(tr_ts),
`endif
        .state(state), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [2:0]  rg;
        logic [15:0] data;
        logic [15:0] seq;
    } ent_t;

    ent_t        mq[$];
    int          m_state;
    logic [15:0] m_seq;
    logic        m_ovf;
    int          m_drop;
    int          total  = 0;
    int          passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_state = 0;
        m_seq   = 16'h0;
        m_ovf   = 1'b0;
        m_drop  = 0;
    endtask

    // Behavioural view of one clock edge, using the inputs as they stand before it.
    task automatic model_edge();
        bit   pop, ev;
        ent_t e;
        if (rst) begin
            model_reset();
            return;
        end
        if (clear) begin
            model_reset();
            return;
        end
        pop = (mq.size() > 0) && tr_ready;
        ev  = 1'b0;
        case (m_state)
            0: if (cap_en) m_state = trig_en ? 1 : 2;
            1: if (!cap_en) m_state = 0;
               else if (wb_we && wb_reg != 0 && wb_pc == trig_pc) begin ev = 1'b1; m_state = 2; end
            2: if (!cap_en) m_state = 0;
               else if (wb_we && wb_reg != 0) ev = 1'b1;
            default: ;
        endcase
        if (pop) void'(mq.pop_front());
        if (ev) begin
            if (mq.size() < DEPTH) begin
                e.pc = wb_pc; e.rg = wb_reg; e.data = wb_data; e.seq = m_seq;
                mq.push_back(e);
                m_seq = m_seq + 16'h1;
            end else begin
                m_ovf = 1'b1;
                if (m_drop < (1 << DROP_W) - 1) m_drop++;
                if (stop_on_full) m_state = 3;
            end
        end
    endtask

    task automatic check_all();
        bit ne;
        ne = (mq.size() > 0);
        chk("tr_valid", 32'(tr_valid), 32'(ne));
        chk("tr_pc",   32'(tr_pc),   ne ? 32'(mq[0].pc)   : 32'h0);
        chk("tr_reg",  32'(tr_reg),  ne ? 32'(mq[0].rg)   : 32'h0);
        chk("tr_data", 32'(tr_data), ne ? 32'(mq[0].data) : 32'h0);
        chk("tr_seq",  32'(tr_seq),  ne ? 32'(mq[0].seq)  : 32'h0);
        chk("state",    32'(state),    32'(m_state));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic ev(input logic [15:0] pc, input logic [2:0] rg, input logic [15:0] d);
        wb_we = 1'b1; wb_pc = pc; wb_reg = rg; wb_data = d;
        step();
        wb_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wb_we = 0; wb_pc = 0; wb_reg = 0; wb_data = 0;
        cap_en = 0; trig_en = 0; trig_pc = 0; stop_on_full = 0; clear = 0; tr_ready = 0;
        model_reset();
        #2;
        check_all();
        step();
        rst = 1'b0;

        // basic capture, push latency 1
        cap_en = 1'b1;
        step();
        chk("enter_capture", 32'(state), 32'd2);
        ev(16'h0005, 3'd3, 16'h1234);
        chk("first_valid", 32'(tr_valid), 32'd1);
        chk("first_data",  32'(tr_data),  32'h1234);
        chk("first_seq",   32'(tr_seq),   32'h0);
        tr_ready = 1'b1; step(); tr_ready = 1'b0;

        // r0 writes are filtered and do not advance seq
        ev(16'h0020, 3'd0, 16'hAAAA);
        chk("r0_no_push", 32'(tr_valid), 32'd0);
        ev(16'h0022, 3'd1, 16'h0001);
        chk("r0_seq_kept", 32'(tr_seq), 32'h1);
        tr_ready = 1'b1; step(); tr_ready = 1'b0;

        // PC trigger
        clear = 1'b1; step(); clear = 1'b0;
        trig_en = 1'b1; trig_pc = 16'h0010;
        step();
        chk("armed", 32'(state), 32'd1);
        ev(16'h0008, 3'd2, 16'h0008);
        ev(16'h000C, 3'd2, 16'h000C);
        chk("armed_empty", 32'(tr_valid), 32'd0);
        ev(16'h0010, 3'd2, 16'h0010);
        chk("trig_state", 32'(state), 32'd2);
        chk("trig_pc_head", 32'(tr_pc), 32'h0010);
        ev(16'h0012, 3'd2, 16'h0012);
        tr_ready = 1'b1; step();
        chk("trig_second_seq", 32'(tr_seq), 32'h1);
        step(); tr_ready = 1'b0;
        trig_en = 1'b0;

        // overflow without freeze
        clear = 1'b1; step(); clear = 1'b0;
        step();
        for (int i = 0; i < 20; i++) ev(16'(16'h0100 + i), 3'd4, 16'(i * 3));
        chk("ovf_set",  32'(overflow), 32'd1);
        chk("ovf_drop", 32'(drop_cnt), 32'd4);
        chk("ovf_head", 32'(tr_seq),   32'h0);

        // full FIFO, push+pop in one cycle
        tr_ready = 1'b1;
        ev(16'h0200, 3'd5, 16'hBEEF);
        chk("pp_no_drop", 32'(drop_cnt), 32'd4);
        for (int i = 0; i < 15; i++) step();
        chk("pp_tail_seq", 32'(tr_seq), 32'h10);
        step();
        tr_ready = 1'b0;

        // stop_on_full freezes
        clear = 1'b1; step(); clear = 1'b0;
        step();
        stop_on_full = 1'b1;
        for (int i = 0; i < 17; i++) ev(16'(16'h0300 + i), 3'd6, 16'(i));
        chk("frozen", 32'(state), 32'd3);
        chk("frozen_drop", 32'(drop_cnt), 32'd1);
        for (int i = 0; i < 3; i++) ev(16'(16'h0400 + i), 3'd6, 16'(i));
        chk("frozen_ignore", 32'(drop_cnt), 32'd1);
        clear = 1'b1; step(); clear = 1'b0;
        chk("clr_valid", 32'(tr_valid), 32'd0);
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_ovf",   32'(overflow), 32'd0);
        stop_on_full = 1'b0;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            wb_we        = ($urandom_range(0, 3) != 0);
            wb_pc        = 16'(16'h0010 + $urandom_range(0, 7));
            wb_reg       = 3'($urandom_range(0, 7));
            wb_data      = 16'($urandom);
            cap_en       = ($urandom_range(0, 15) != 0);
            trig_en      = 1'($urandom_range(0, 1));
            trig_pc      = ($urandom_range(0, 1) != 0) ? 16'h0012 : 16'h0015;
            stop_on_full = ($urandom_range(0, 7) == 0);
            clear        = ($urandom_range(0, 63) == 0);
            tr_ready     = ($urandom_range(0, 2) == 0);
            step();
        end
        clear = 1'b0;

        // asynchronous reset in the middle of a burst
        cap_en = 1'b1; tr_ready = 1'b0; stop_on_full = 1'b0;
        clear = 1'b1; step(); clear = 1'b0;
        step();
        for (int i = 0; i < 5; i++) ev(16'(16'h0500 + i), 3'd7, 16'(i + 1));
        wb_we = 1'b1; wb_reg = 3'd7;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("async_rst_valid", 32'(tr_valid), 32'd0);
        wb_we = 1'b0;
        #2;
        step();
        rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/risc16_trace_buffer.md
# risc16_trace_buffer

Execution-trace capture buffer sitting directly downstream of the RiSC-16 processor core. It snoops the register-file writeback port (write enable, PC, destination register, write data), optionally waits for a PC trigger, and queues each retired register write into a first-word-fall-through FIFO drained by a host over a valid/ready handshake. It replaces ad-hoc `$monitor` inspection with a synthesizable, bench- and board-usable trace stream.

## Interface
- DEPTH, 16, FIFO entries; power of two, 4..256
- DROP_W, 8, width of saturating drop counter
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wb_we  in  1  register-file write enable from core (one event per cycle high)
- wb_pc  in  16  PC of the retiring instruction
- wb_reg  in  3  destination register index
- wb_data  in  16  value written
- cap_en  in  1  level; enables capture
- trig_en  in  1  level; sampled on IDLE exit, selects ARMED start
- trig_pc  in  16  trigger PC
- stop_on_full  in  1  level; FIFO full + new event freezes capture
- clear  in  1  one-cycle pulse; flush and return to IDLE
- tr_valid  out  1  head entry available
- tr_ready  in  1  host accepts head entry
- tr_pc / tr_reg / tr_data  out  16/3/16  head entry fields
- tr_seq  out  16  sequence number of head entry
- state  out  2  IDLE=0, ARMED=1, CAPTURE=2, FROZEN=3
- overflow  out  1  sticky: at least one event dropped
- drop_cnt  out  DROP_W  dropped events, saturating

## Operation
- Qualified event: wb_we=1 and wb_reg!=0 (r0 writes never captured).
- FSM: IDLE -> (cap_en=1) ARMED if trig_en else CAPTURE. ARMED -> CAPTURE on qualified event with wb_pc==trig_pc; that event is pushed. CAPTURE -> IDLE when cap_en=0. CAPTURE -> FROZEN when qualified event arrives, FIFO full (after same-cycle pop), stop_on_full=1; that event is dropped. FROZEN -> IDLE only on clear. ARMED -> IDLE when cap_en=0.
- Push only in CAPTURE (or the triggering ARMED cycle). Entry = {pc, reg, data, seq}; seq counter increments per push, 16-bit wrap 0xFFFF->0x0000.
- Full and no pop: event dropped, overflow set, drop_cnt +1 saturating at 2^DROP_W-1.
- Pop when tr_valid & tr_ready; pop allowed in every state including FROZEN and IDLE.
- clear: highest priority; empties FIFO, zeroes seq, overflow, drop_cnt, state=IDLE; same-cycle push/pop ignored.

## Timing
- Reset values: tr_valid=0, tr_pc/tr_reg/tr_data/tr_seq=0, state=IDLE, overflow=0, drop_cnt=0.
- Push latency 1: event sampled at edge N appears on tr_* after edge N (tr_valid=1 in cycle N+1 if FIFO was empty). No combinational path wb_* -> tr_*.
- FWFT: tr_* hold stable while tr_valid=1 and tr_ready=0.
- Simultaneous push+pop when full: both accepted, count unchanged, no drop. When empty: push only (tr_valid was 0).
- One push and one pop per cycle max; sustained throughput 1 event/cycle.
- state output registered; FSM transition visible the cycle after the causing edge.
- rst mid-operation: all state cleared immediately, asynchronously; in-flight event lost.

## Configuration
- RISC16_TRACE_TIMESTAMP_EN defined: 32-bit free-running cycle counter (reset 0, counts every clk, wraps) stored per entry; extra output tr_ts [31:0] (reset 0). clear zeroes the counter.
- Undefined: no counter, no tr_ts port, entry width 51 bits.

## Structure
- Shared package risc16_pkg: state enum (IDLE/ARMED/CAPTURE/FROZEN), REG_W=3, WORD_W=16, trace entry struct/width constant.
- One sub-module: risc16_trace_fifo (parameterised sync FWFT FIFO, DEPTH x entry width, push/pop/full/empty/flush). FSM, filter, counters in top.

## Test plan
- Reset then cap_en=1, trig_en=0; wb_we with reg=3,data=0x1234,pc=0x0005 -> next cycle tr_valid=1, tr_reg=3, tr_data=0x1234, tr_seq=0.
- Write to r0 (wb_reg=0, wb_we=1) in CAPTURE -> no push, tr_valid stays 0, seq unchanged.
- trig_en=1, trig_pc=0x0010; events at pc 0x0008,0x000C,0x0010,0x0012 -> only 0x0010 and 0x0012 queued, seq 0 and 1, state ARMED->CAPTURE.
- DEPTH=16, tr_ready=0, stop_on_full=0, 20 events -> 16 stored, overflow=1, drop_cnt=4; with stop_on_full=1 -> state=FROZEN at event 17, drop_cnt=1, later events ignored.
- Full FIFO, push+pop same cycle -> no drop, popped entry seq=0, new tail seq=16.
- clear while FROZEN with 16 entries -> next cycle tr_valid=0, state=IDLE, overflow=0, drop_cnt=0; assert rst mid-burst -> all outputs at reset values asynchronously.
